padding_stream: RTL

//  Streaming zero-padding stage for the convolution datapath. Sits between the feature-map source and the

---
 rtl/padding_pkg.sv | 17 +
 rtl/pad_pos_counter.sv | 49 ++++
 rtl/padding_stream.sv | 111 +++++++++++
 3 files changed

// File: rtl/padding_pkg.sv
// Shared definitions for the padding_stream family: FSM encoding, limits and output-size helper.
package padding_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pad_state_t;

  localparam int PAD_MAX       = 8;
  localparam int CNT_W_DEFAULT = 16;

  // Output frame dimension for an input dimension d bordered by pad on both sides.
  function automatic int out_dim(input int d, input int pad);
    return d + 2 * pad;
  endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// Raster position tracker over the padded output grid; classifies each position as border or interior.
module pad_pos_counter #(
  parameter int R     = 222,
  parameter int C     = 222,
  parameter int PAD   = 1,
  parameter int W     = 220,
  parameter int H     = 220,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             border,
  output logic             last_col,
  output logic             last_pos
);

  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(R - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(C - 1);
  localparam logic [CNT_W-1:0] PAD_L    = CNT_W'(PAD);
  localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(PAD + H);
  localparam logic [CNT_W-1:0] COL_END  = CNT_W'(PAD + W);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  assign last_col = (col == COL_LAST);
  assign last_pos = last_col && (row == ROW_LAST);
  assign border   = (row < PAD_L) || (row >= ROW_END) || (col < PAD_L) || (col >= COL_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= last_pos ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

endmodule

// File: rtl/padding_stream.sv
// Streaming zero-padding stage: borders each W x H frame with PAD pixels of a per-frame pad value.
module padding_stream
  import padding_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int W          = 220,
  parameter int H          = 220,
  parameter int PAD        = 1,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pad_val,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy
);

  localparam int R = out_dim(H, PAD);
  localparam int C = out_dim(W, PAD);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a presented output is held unchanged until it is taken.
  pad_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] pad_q;
  logic [DATA_WIDTH-1:0] emit_data;
  logic                  ld, emit, start;
  logic [CNT_W-1:0]      row, col;
  logic                  border, last_col, last_pos;
  logic                  unused_pos;

  pad_pos_counter #(
    .R(R), .C(C), .PAD(PAD), .W(W), .H(H), .CNT_W(CNT_W)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .advance  (emit),
    .row      (row),
    .col      (col),
    .border   (border),
    .last_col (last_col),
    .last_pos (last_pos)
  );

  // Raw position is only meaningful to debug probes; border/last flags carry the decisions.
  assign unused_pos = ^{row, col};

  assign busy = (state_q == ST_ACTIVE);

  always_comb begin
    ld        = !out_valid || out_ready;
    emit      = 1'b0;
    in_ready  = 1'b0;
    start     = 1'b0;
    state_d   = state_q;
    emit_data = border ? pad_q : in_data;
    case (state_q)
      ST_IDLE: begin
        // The pixel that wakes us up is not consumed here; it waits for the first interior slot.
        if (in_valid) begin
          start   = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (border) begin
          emit = ld;
        end else begin
          in_ready = ld;
          emit     = ld && in_valid;
        end
        if (emit && last_pos) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) pad_q <= pad_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (ld) begin
      out_valid <= emit;
      if (emit) begin
        out_data <= emit_data;
        out_eol  <= last_col;
        out_eof  <= last_pos;
      end
    end
  end

endmodule
